// File: rtl/pipeline_hazard_ctrl_if.sv
// Pipeline hazard controller bundle: hazard inputs from IF/ID/EX/MEM stages and
// the stall/flush/redirect controls plus status counters returned to them.
interface pipeline_hazard_ctrl_if #(
  parameter int unsigned CNT_W = 16
);
  logic             CS_Branch;
  logic             IDEX_MemRead;
  logic [4:0]       IDEX_Rt;
  logic [4:0]       ID_Rs;
  logic [4:0]       ID_Rt;
  logic             ID_UsesRt;
  logic             IMem_Ready;
  logic             PC_Write;
  logic             Redirect;
  logic             IFID_Write;
  logic             IFID_Flush;
  logic             IDEX_Flush;
  logic             EXMEM_Flush;
  logic [1:0]       Ctrl_State;
  logic [CNT_W-1:0] Stall_Count;
  logic [CNT_W-1:0] Flush_Count;
  logic             Fetch_Fault;

  modport master (
    output CS_Branch, IDEX_MemRead, IDEX_Rt, ID_Rs, ID_Rt, ID_UsesRt, IMem_Ready,
    input  PC_Write, Redirect, IFID_Write, IFID_Flush, IDEX_Flush, EXMEM_Flush,
    input  Ctrl_State, Stall_Count, Flush_Count, Fetch_Fault
  );

  modport slave (
    input  CS_Branch, IDEX_MemRead, IDEX_Rt, ID_Rs, ID_Rt, ID_UsesRt, IMem_Ready,
    output PC_Write, Redirect, IFID_Write, IFID_Flush, IDEX_Flush, EXMEM_Flush,
    output Ctrl_State, Stall_Count, Flush_Count, Fetch_Fault
  );
endinterface

// File: rtl/pipeline_hazard_ctrl.sv
// Five-stage pipeline sequencer: branch flush, load-use stall and imem-wait bubbles,
// with saturating stall/flush counters and a sticky fetch-timeout fault.
module pipeline_hazard_ctrl #(
  parameter int unsigned LOAD_STALLS  = 1,
  parameter int unsigned IMEM_TIMEOUT = 64,
  parameter int unsigned CNT_W        = 16
) (
  input  logic                  clock,
  input  logic                  reset,
  pipeline_hazard_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    STALL = 2'd1,
    WAIT  = 2'd2
  } state_t;

  state_t           r_state;
  logic [3:0]       r_rem;
  logic [7:0]       r_wait_cnt;
  logic [CNT_W-1:0] r_stall_cnt;
  logic [CNT_W-1:0] r_flush_cnt;
  logic             r_fault;

  logic             w_hazard;
  logic             w_load_use;
  logic [7:0]       w_wait_inc;
  logic             w_timeout;
  logic [CNT_W-1:0] w_stall_inc;
  logic [CNT_W-1:0] w_flush_inc;

  assign w_hazard = bus.IDEX_MemRead && (bus.IDEX_Rt != 5'd0) &&
                    ((bus.IDEX_Rt == bus.ID_Rs) ||
                     (bus.ID_UsesRt && (bus.IDEX_Rt == bus.ID_Rt)));

  // A pending STALL keeps bubbling regardless of the current ID/EX contents;
  // a fresh hazard in WAIT also wins over the imem wait.
  assign w_load_use = (r_state == STALL) || w_hazard;

  assign w_wait_inc  = (r_wait_cnt == '1) ? r_wait_cnt : r_wait_cnt + 8'd1;
  assign w_timeout   = 32'(w_wait_inc) >= IMEM_TIMEOUT;
  assign w_stall_inc = (r_stall_cnt == '1) ? r_stall_cnt : r_stall_cnt + CNT_W'(1);
  assign w_flush_inc = (r_flush_cnt == '1) ? r_flush_cnt : r_flush_cnt + CNT_W'(1);

  always_comb begin
    bus.PC_Write    = 1'b0;
    bus.Redirect    = 1'b0;
    bus.IFID_Write  = 1'b0;
    bus.IFID_Flush  = 1'b0;
    bus.IDEX_Flush  = 1'b0;
    bus.EXMEM_Flush = 1'b0;
    if (reset) begin
      if (bus.CS_Branch) begin
        bus.PC_Write    = 1'b1;
        bus.Redirect    = 1'b1;
        bus.IFID_Write  = 1'b1;
        bus.IFID_Flush  = 1'b1;
        bus.IDEX_Flush  = 1'b1;
        bus.EXMEM_Flush = 1'b1;
      end else if (w_load_use) begin
        bus.IDEX_Flush  = 1'b1;
      end else if (!bus.IMem_Ready) begin
        bus.IFID_Write  = 1'b1;
        bus.IFID_Flush  = 1'b1;
      end else begin
        bus.PC_Write    = 1'b1;
        bus.IFID_Write  = 1'b1;
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state     <= RUN;
      r_rem       <= '0;
      r_wait_cnt  <= '0;
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
      r_fault     <= 1'b0;
    end else if (bus.CS_Branch) begin
      r_flush_cnt <= w_flush_inc;
      r_rem       <= '0;
      if (!bus.IMem_Ready) begin
        r_state    <= WAIT;
        r_wait_cnt <= w_wait_inc;
        if (w_timeout) r_fault <= 1'b1;
      end else begin
        r_state    <= RUN;
        r_wait_cnt <= '0;
      end
    end else if (w_load_use) begin
      r_stall_cnt <= w_stall_inc;
      if (r_state == STALL) begin
        r_rem <= r_rem - 4'd1;
        if (r_rem <= 4'd1) r_state <= RUN;
      end else if (LOAD_STALLS > 1) begin
        r_state <= STALL;
        r_rem   <= 4'(LOAD_STALLS - 1);
      end else begin
        r_state <= RUN;
      end
    end else if (!bus.IMem_Ready) begin
      r_state    <= WAIT;
      r_wait_cnt <= w_wait_inc;
      if (w_timeout) r_fault <= 1'b1;
    end else begin
      r_state    <= RUN;
      r_wait_cnt <= '0;
    end
  end

  assign bus.Ctrl_State  = r_state;
  assign bus.Stall_Count = r_stall_cnt;
  assign bus.Flush_Count = r_flush_cnt;
  assign bus.Fetch_Fault = r_fault;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Scoreboard bench for pipeline_hazard_ctrl: two instances (3-bubble/64-timeout/16-bit and
// 1-bubble/4-timeout/2-bit counters) share stimulus and are checked against a reference model.
module tb_pipeline_hazard_ctrl;

  logic clock = 1'b0;
  logic reset = 1'b0;

  pipeline_hazard_ctrl_if #(.CNT_W(16)) bus_a ();
  pipeline_hazard_ctrl_if #(.CNT_W(2))  bus_b ();

  pipeline_hazard_ctrl #(.LOAD_STALLS(3), .IMEM_TIMEOUT(64), .CNT_W(16)) dut_a (
    .clock(clock), .reset(reset), .bus(bus_a.slave)
  );
  pipeline_hazard_ctrl #(.LOAD_STALLS(1), .IMEM_TIMEOUT(4), .CNT_W(2)) dut_b (
    .clock(clock), .reset(reset), .bus(bus_b.slave)
  );

  always #5 clock = ~clock;

  // ctl bit order: {PC_Write, Redirect, IFID_Write, IFID_Flush, IDEX_Flush, EXMEM_Flush}
  typedef struct packed {
    logic [5:0]  ctl;
    logic [1:0]  st;
    logic [15:0] scnt;
    logic [15:0] fcnt;
    logic        fault;
  } exp_t;

  exp_t        sb_q[$];
  int unsigned n_checks = 0;
  int unsigned n_errors = 0;
  int unsigned cyc = 0;

  int          m_st[2];
  int          m_rem[2];
  int          m_wait[2];
  int          m_scnt[2];
  int          m_fcnt[2];
  bit          m_fault[2];
  int          p_ls[2]   = '{3, 1};
  int          p_to[2]   = '{64, 4};
  int          p_cmax[2] = '{65535, 3};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got !== want) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, want);
    end
  endtask

  task automatic model_step(input int d, input logic rst, input logic br, input logic mr,
                            input logic [4:0] xrt, input logic [4:0] rs, input logic [4:0] rt,
                            input logic uses, input logic rdy, output exp_t e);
    bit haz;
    e = '0;
    if (!rst) begin
      m_st[d] = 0; m_rem[d] = 0; m_wait[d] = 0;
      m_scnt[d] = 0; m_fcnt[d] = 0; m_fault[d] = 1'b0;
      return;
    end
    haz = mr && (xrt != 5'd0) && ((xrt == rs) || (uses && (xrt == rt)));
    e.st    = 2'(m_st[d]);
    e.scnt  = 16'(m_scnt[d]);
    e.fcnt  = 16'(m_fcnt[d]);
    e.fault = m_fault[d];
    if (br) begin
      e.ctl = 6'b111111;
      if (m_fcnt[d] < p_cmax[d]) m_fcnt[d]++;
      m_rem[d] = 0;
      if (!rdy) begin
        if (m_wait[d] < 255) m_wait[d]++;
        if (m_wait[d] >= p_to[d]) m_fault[d] = 1'b1;
        m_st[d] = 2;
      end else begin
        m_wait[d] = 0;
        m_st[d] = 0;
      end
    end else if (m_st[d] == 1 || haz) begin
      e.ctl = 6'b000010;
      if (m_scnt[d] < p_cmax[d]) m_scnt[d]++;
      if (m_st[d] == 1) begin
        m_rem[d]--;
        if (m_rem[d] == 0) m_st[d] = 0;
      end else if (p_ls[d] > 1) begin
        m_st[d] = 1;
        m_rem[d] = p_ls[d] - 1;
      end else begin
        m_st[d] = 0;
      end
    end else if (!rdy) begin
      e.ctl = 6'b001100;
      if (m_wait[d] < 255) m_wait[d]++;
      if (m_wait[d] >= p_to[d]) m_fault[d] = 1'b1;
      m_st[d] = 2;
    end else begin
      e.ctl = 6'b101000;
      m_wait[d] = 0;
      m_st[d] = 0;
    end
  endtask

  task automatic compare_dut(input int d, input logic [5:0] ctl, input logic [1:0] st,
                             input logic [31:0] sc, input logic [31:0] fc, input logic flt);
    exp_t  e;
    string id;
    id = $sformatf("%s@%0d", (d == 0) ? "a" : "b", cyc);
    if (sb_q.size() == 0) begin
      n_checks++;
      n_errors++;
      $display("FAIL %s.sb: got empty scoreboard expected entry", id);
      return;
    end
    e = sb_q.pop_front();
    check({id, ".ctl"},   32'(ctl), 32'(e.ctl));
    check({id, ".state"}, 32'(st),  32'(e.st));
    check({id, ".stall"}, sc,       32'(e.scnt));
    check({id, ".flush"}, fc,       32'(e.fcnt));
    check({id, ".fault"}, 32'(flt), 32'(e.fault));
  endtask

  task automatic drive(input logic rst, input logic br, input logic mr, input logic [4:0] xrt,
                       input logic [4:0] rs, input logic [4:0] rt, input logic uses,
                       input logic rdy);
    exp_t e;
    @(negedge clock);
    cyc++;
    reset = rst;
    bus_a.CS_Branch = br;  bus_a.IDEX_MemRead = mr; bus_a.IDEX_Rt = xrt;
    bus_a.ID_Rs = rs;      bus_a.ID_Rt = rt;        bus_a.ID_UsesRt = uses;
    bus_a.IMem_Ready = rdy;
    bus_b.CS_Branch = br;  bus_b.IDEX_MemRead = mr; bus_b.IDEX_Rt = xrt;
    bus_b.ID_Rs = rs;      bus_b.ID_Rt = rt;        bus_b.ID_UsesRt = uses;
    bus_b.IMem_Ready = rdy;
    for (int d = 0; d < 2; d++) begin
      model_step(d, rst, br, mr, xrt, rs, rt, uses, rdy, e);
      sb_q.push_back(e);
    end
    #2;
    compare_dut(0, {bus_a.PC_Write, bus_a.Redirect, bus_a.IFID_Write, bus_a.IFID_Flush,
                    bus_a.IDEX_Flush, bus_a.EXMEM_Flush}, bus_a.Ctrl_State,
                32'(bus_a.Stall_Count), 32'(bus_a.Flush_Count), bus_a.Fetch_Fault);
    compare_dut(1, {bus_b.PC_Write, bus_b.Redirect, bus_b.IFID_Write, bus_b.IFID_Flush,
                    bus_b.IDEX_Flush, bus_b.EXMEM_Flush}, bus_b.Ctrl_State,
                32'(bus_b.Stall_Count), 32'(bus_b.Flush_Count), bus_b.Fetch_Fault);
  endtask

  task automatic idle(input int n);
    repeat (n) drive(1'b1, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1);
  endtask

  task automatic hazard();
    drive(1'b1, 1'b0, 1'b1, 5'd5, 5'd5, 5'd0, 1'b0, 1'b1);
  endtask

  task automatic branch(input logic rdy);
    drive(1'b1, 1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, rdy);
  endtask

  task automatic imem_wait(input int n);
    repeat (n) drive(1'b1, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
  endtask

  initial begin
    bus_a.CS_Branch = 1'b0; bus_a.IDEX_MemRead = 1'b0; bus_a.IDEX_Rt = '0;
    bus_a.ID_Rs = '0; bus_a.ID_Rt = '0; bus_a.ID_UsesRt = 1'b0; bus_a.IMem_Ready = 1'b1;
    bus_b.CS_Branch = 1'b0; bus_b.IDEX_MemRead = 1'b0; bus_b.IDEX_Rt = '0;
    bus_b.ID_Rs = '0; bus_b.ID_Rt = '0; bus_b.ID_UsesRt = 1'b0; bus_b.IMem_Ready = 1'b1;

    // reset held, with a branch present to show outputs stay quiet
    drive(1'b0, 1'b1, 1'b1, 5'd5, 5'd5, 5'd0, 1'b0, 1'b1);
    drive(1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1);
    idle(2);

    // single load-use hazard: 3 bubbles on a, 1 on b
    hazard();
    idle(4);

    // non-hazards: rt==0, rt-only match without uses; then rt match with uses
    drive(1'b1, 1'b0, 1'b1, 5'd0, 5'd0, 5'd0, 1'b1, 1'b1);
    drive(1'b1, 1'b0, 1'b1, 5'd7, 5'd3, 5'd7, 1'b0, 1'b1);
    drive(1'b1, 1'b0, 1'b0, 5'd7, 5'd7, 5'd7, 1'b1, 1'b1);
    drive(1'b1, 1'b0, 1'b1, 5'd7, 5'd3, 5'd7, 1'b1, 1'b1);
    idle(4);

    // branch aborting a stall with rem=2
    hazard();
    branch(1'b1);
    idle(2);

    // branch while imem not ready, then recovery
    branch(1'b0);
    idle(2);

    // fetch timeout
    imem_wait(64);
    idle(3);

    // load-use during WAIT
    imem_wait(1);
    drive(1'b1, 1'b0, 1'b1, 5'd9, 5'd9, 5'd0, 1'b0, 1'b0);
    idle(4);

    // counter saturation (2-bit counters on b)
    repeat (5) begin
      hazard();
      idle(3);
      branch(1'b1);
    end

    // reset dropped mid-WAIT, then mid-STALL
    imem_wait(2);
    drive(1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
    drive(1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1);
    idle(2);
    hazard();
    drive(1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1);
    idle(2);

    // randomised traffic
    repeat (300) begin
      drive(1'($urandom_range(0, 49) != 0), 1'($urandom_range(0, 7) == 0),
            1'($urandom_range(0, 1)), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
            5'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
            1'($urandom_range(0, 3) != 0));
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
